// File: rtl/proc_pkg.sv
// Shared definitions for the instruction fetch unit: state encodings, widths, HLT opcode.
// Used by instr_fetch and fetch_pbuf (the latter built only with FETCH_PREFETCH_EN).
package proc_pkg;

   localparam int PC_W   = 8;
   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] OPC_HLT = 8'hFF;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   // Program counter advance; 8'hFF wraps naturally to 8'h00.
   function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] p);
      return p + {{(PC_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/fetch_pbuf.sv
// One-byte prefetch buffer holding the instruction after the one being issued.
// Present only when FETCH_PREFETCH_EN is defined; clear has priority over load.
module fetch_pbuf
   import proc_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] pbuf,
   output logic              pbuf_valid
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pbuf       <= '0;
         pbuf_valid <= 1'b0;
      end else if (clear) begin
         pbuf_valid <= 1'b0;
      end else if (load) begin
         pbuf       <= data;
         pbuf_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads program bytes, issues them to the controller, halts on HLT.
// Optional FETCH_PREFETCH_EN adds a one-byte prefetch buffer for back-to-back issue.
module instr_fetch
   import proc_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   output logic [PC_W-1:0]   mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] opcode,
   output logic              op,
   input  logic              ctrl_done,
   input  logic              pc_load,
   input  logic [PC_W-1:0]   pc_load_val,
   output logic [PC_W-1:0]   pc,
   output logic              halted
);

   state_t state, state_nx;

   logic              accept;
   logic              done_edge;
   logic              mem_rd_nx;
   logic              op_nx;
   logic              halted_nx;
   logic [DATA_W-1:0] opcode_nx;
   logic [PC_W-1:0]   pc_nx;
   logic [DATA_W-1:0] pbuf;
   logic              pbuf_valid;

   assign accept    = mem_rd & mem_ready;
   assign done_edge = (state == ST_ISSUE) & op & ctrl_done;
   assign mem_addr  = pc;

`ifdef FETCH_PREFETCH_EN
   localparam bit PF_EN = 1'b1;

   // A byte accepted on the done edge goes straight to opcode, so only park it otherwise.
   fetch_pbuf u_pbuf (
      .clk        (clk),
      .reset      (reset),
      .load       ((state == ST_ISSUE) & accept & ~done_edge),
      .clear      (done_edge),
      .data       (mem_rdata),
      .pbuf       (pbuf),
      .pbuf_valid (pbuf_valid)
   );
`else
   localparam bit PF_EN = 1'b0;

   assign pbuf       = '0;
   assign pbuf_valid = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_FETCH;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_FETCH: if (accept) state_nx = ST_ISSUE;
         ST_ISSUE: begin
            if (done_edge) begin
               if (opcode == OPC_HLT)                     state_nx = ST_HALT;
               else if (pc_load)                          state_nx = ST_FETCH;
               else if (PF_EN && (pbuf_valid || accept))  state_nx = ST_ISSUE;
               else                                       state_nx = ST_FETCH;
            end
         end
         ST_HALT:  state_nx = ST_HALT;
         default:  state_nx = ST_FETCH;
      endcase
   end

   always_comb begin
      mem_rd_nx = mem_rd;
      op_nx     = op;
      opcode_nx = opcode;
      pc_nx     = pc;
      halted_nx = halted;
      if (accept) pc_nx = pc_next(pc);
      case (state)
         ST_FETCH: begin
            mem_rd_nx = 1'b1;
            if (accept) begin
               opcode_nx = mem_rdata;
               op_nx     = 1'b1;
               mem_rd_nx = PF_EN && (mem_rdata != OPC_HLT);
            end
         end
         ST_ISSUE: begin
            // Buffer just filled: stop prefetching until it drains.
            if (PF_EN && accept) mem_rd_nx = 1'b0;
            if (done_edge) begin
               if (pc_load) pc_nx = pc_load_val;
               if (opcode == OPC_HLT) begin
                  op_nx     = 1'b0;
                  mem_rd_nx = 1'b0;
                  halted_nx = 1'b1;
               end else if (pc_load) begin
                  op_nx     = 1'b0;
                  mem_rd_nx = 1'b0;
               end else if (PF_EN && pbuf_valid) begin
                  opcode_nx = pbuf;
                  mem_rd_nx = (pbuf != OPC_HLT);
               end else if (PF_EN && accept) begin
                  opcode_nx = mem_rdata;
                  mem_rd_nx = (mem_rdata != OPC_HLT);
               end else begin
                  op_nx     = 1'b0;
                  mem_rd_nx = 1'b1;
               end
            end
         end
         ST_HALT: begin
            mem_rd_nx = 1'b0;
            op_nx     = 1'b0;
            halted_nx = 1'b1;
         end
         default: begin
            mem_rd_nx = 1'b0;
            op_nx     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_rd <= 1'b0;
         op     <= 1'b0;
         opcode <= '0;
         pc     <= '0;
         halted <= 1'b0;
      end else begin
         mem_rd <= mem_rd_nx;
         op     <= op_nx;
         opcode <= opcode_nx;
         pc     <= pc_nx;
         halted <= halted_nx;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fetch/issue latency, wait states, branch, wrap, halt, reset,
// and (with FETCH_PREFETCH_EN) back-to-back issue and prefetch flush.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] mem_addr;
   logic       mem_rd;
   logic [7:0] mem_rdata;
   logic       mem_ready;
   logic [7:0] opcode;
   logic       op;
   logic       ctrl_done;
   logic       pc_load;
   logic [7:0] pc_load_val;
   logic [7:0] pc;
   logic       halted;

   logic [7:0] mem [256];
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   instr_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .opcode      (opcode),
      .op          (op),
      .ctrl_done   (ctrl_done),
      .pc_load     (pc_load),
      .pc_load_val (pc_load_val),
      .pc          (pc),
      .halted      (halted)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[8'h00] = 8'h1D;
      reset = 1'b0; mem_ready = 1'b0; ctrl_done = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00;

      #12;
      chk("rst_pc", pc, 8'h00);
      chk("rst_opcode", opcode, 8'h00);
      chk("rst_op", {7'd0, op}, 8'h00);
      chk("rst_mem_rd", {7'd0, mem_rd}, 8'h00);
      chk("rst_halted", {7'd0, halted}, 8'h00);

      @(negedge clk) reset = 1'b1;
      tick;
      chk("fetch0_rd", {7'd0, mem_rd}, 8'h01);
      chk("fetch0_addr", mem_addr, 8'h00);
      chk("fetch0_op", {7'd0, op}, 8'h00);

      mem_ready = 1'b1; tick; mem_ready = 1'b0;
      chk("issue0_op", {7'd0, op}, 8'h01);
      chk("issue0_opcode", opcode, 8'h1D);
      chk("issue0_pc", pc, 8'h01);

`ifndef FETCH_PREFETCH_EN
      chk("issue0_no_rd", {7'd0, mem_rd}, 8'h00);
      ctrl_done = 1'b1; tick; ctrl_done = 1'b0;
      chk("done0_op", {7'd0, op}, 8'h00);
      chk("done0_rd", {7'd0, mem_rd}, 8'h01);
      chk("done0_addr", mem_addr, 8'h01);

      mem[8'h01] = 8'h22;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("wait_rd", {7'd0, mem_rd}, 8'h01);
         chk("wait_addr", mem_addr, 8'h01);
         chk("wait_op", {7'd0, op}, 8'h00);
      end
      mem_ready = 1'b1; tick; mem_ready = 1'b0;
      chk("wait_issue_op", {7'd0, op}, 8'h01);
      chk("wait_issue_opcode", opcode, 8'h22);
      chk("wait_issue_pc", pc, 8'h02);

      pc_load = 1'b1; pc_load_val = 8'h77; tick; pc_load = 1'b0;
      chk("stray_load_pc", pc, 8'h02);
      chk("stray_load_op", {7'd0, op}, 8'h01);
      chk("stray_load_opcode", opcode, 8'h22);

      ctrl_done = 1'b1; pc_load = 1'b1; pc_load_val = 8'h40; tick;
      ctrl_done = 1'b0; pc_load = 1'b0;
      chk("branch_op", {7'd0, op}, 8'h00);
      chk("branch_addr", mem_addr, 8'h40);
      tick;
      chk("branch_rd", {7'd0, mem_rd}, 8'h01);
      chk("branch_addr2", mem_addr, 8'h40);
      chk("branch_op2", {7'd0, op}, 8'h00);
      mem[8'h40] = 8'h55;
      mem_ready = 1'b1; tick; mem_ready = 1'b0;
      chk("branch_opcode", opcode, 8'h55);
      chk("branch_pc", pc, 8'h41);

      ctrl_done = 1'b1; pc_load = 1'b1; pc_load_val = 8'hFF; tick;
      ctrl_done = 1'b0; pc_load = 1'b0;
      chk("ld_ff_pc", pc, 8'hFF);
      tick;
      chk("ff_rd", {7'd0, mem_rd}, 8'h01);
      chk("ff_addr", mem_addr, 8'hFF);
      mem[8'hFF] = 8'h33;
      mem_ready = 1'b1; tick; mem_ready = 1'b0;
      chk("wrap_opcode", opcode, 8'h33);
      chk("wrap_pc", pc, 8'h00);
      ctrl_done = 1'b1; tick; ctrl_done = 1'b0;
      chk("wrap_fetch_addr", mem_addr, 8'h00);
      chk("wrap_fetch_rd", {7'd0, mem_rd}, 8'h01);

      mem[8'h00] = 8'hFF;
      mem_ready = 1'b1; tick; mem_ready = 1'b0;
      chk("hlt_opcode", opcode, 8'hFF);
      chk("hlt_op", {7'd0, op}, 8'h01);
      chk("hlt_pc", pc, 8'h01);
      ctrl_done = 1'b1; tick; ctrl_done = 1'b0;
      chk("halt_halted", {7'd0, halted}, 8'h01);
      chk("halt_op", {7'd0, op}, 8'h00);
      chk("halt_rd", {7'd0, mem_rd}, 8'h00);

      ctrl_done = 1'b1; pc_load = 1'b1; pc_load_val = 8'h10; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("halt_stay", {7'd0, halted}, 8'h01);
         chk("halt_stay_rd", {7'd0, mem_rd}, 8'h00);
         chk("halt_stay_pc", pc, 8'h01);
      end
      ctrl_done = 1'b0; pc_load = 1'b0; mem_ready = 1'b0;

      reset = 1'b0; #2;
      chk("halt_rst_halted", {7'd0, halted}, 8'h00);
      chk("halt_rst_pc", pc, 8'h00);
      @(negedge clk) reset = 1'b1;
      tick;
      chk("post_halt_rd", {7'd0, mem_rd}, 8'h01);
      chk("post_halt_addr", mem_addr, 8'h00);
`else
      chk("issue0_prefetch_rd", {7'd0, mem_rd}, 8'h01);
      reset = 1'b0; #2;
      chk("pf_rst_op", {7'd0, op}, 8'h00);
      mem[8'h00] = 8'h01; mem[8'h01] = 8'h02; mem[8'h02] = 8'h03; mem[8'h40] = 8'h66;
      @(negedge clk) reset = 1'b1;
      tick;
      chk("pf_fetch_rd", {7'd0, mem_rd}, 8'h01);
      chk("pf_fetch_addr", mem_addr, 8'h00);
      mem_ready = 1'b1; tick;
      chk("pf_issue1_opcode", opcode, 8'h01);
      chk("pf_issue1_op", {7'd0, op}, 8'h01);
      chk("pf_issue1_rd", {7'd0, mem_rd}, 8'h01);
      chk("pf_issue1_addr", mem_addr, 8'h01);
      ctrl_done = 1'b1; tick; ctrl_done = 1'b0;
      chk("pf_issue2_op", {7'd0, op}, 8'h01);
      chk("pf_issue2_opcode", opcode, 8'h02);
      chk("pf_issue2_pc", pc, 8'h02);
      tick; mem_ready = 1'b0;
      chk("pf_buf_pc", pc, 8'h03);
      chk("pf_buf_rd", {7'd0, mem_rd}, 8'h00);
      chk("pf_buf_opcode", opcode, 8'h02);
      ctrl_done = 1'b1; pc_load = 1'b1; pc_load_val = 8'h40; tick;
      ctrl_done = 1'b0; pc_load = 1'b0;
      chk("pf_flush_op", {7'd0, op}, 8'h00);
      chk("pf_flush_pc", pc, 8'h40);
      chk("pf_flush_rd", {7'd0, mem_rd}, 8'h00);
      tick;
      chk("pf_refetch_rd", {7'd0, mem_rd}, 8'h01);
      chk("pf_refetch_addr", mem_addr, 8'h40);
      mem_ready = 1'b1; tick; mem_ready = 1'b0;
      chk("pf_refetch_opcode", opcode, 8'h66);
      chk("pf_refetch_pc", pc, 8'h41);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
